// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, burst-granular arbiter sharing the TX FIFO write port.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req,
    input  logic [8*NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          grant,
    output logic                     fifo_wen,
    output logic [7:0]               fifo_wdata,
    input  logic                     fifo_full,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]          r_state;
    logic [c_IDX_W-1:0]  r_rrPtr;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_CNT_W-1:0]  r_beatCnt;

    logic                w_ownerReq;
    logic                w_ownerLast;
    logic [7:0]          w_ownerData;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_pick;
    logic [c_IDX_W-1:0]  w_nextPtr;
    logic                w_isBusy;
    logic                w_accept;
    logic                w_lastBeat;
    logic                w_burstEnd;

    // Lanes belonging to the current owner
    always_comb begin
        w_ownerReq  = 1'b0;
        w_ownerLast = 1'b0;
        w_ownerData = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_IDX_W'(i)) begin
                w_ownerReq  = req[i];
                w_ownerLast = req_last[i];
                w_ownerData = req_data[8*i +: 8];
            end
        end
    end

    // First requester at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rrPtr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = c_IDX_W'((int'(r_rrPtr) + k) % NREQ);
            end
        end
    end

    assign w_nextPtr  = c_IDX_W'((int'(r_owner) + 1) % NREQ);
    assign w_isBusy   = (r_state == c_BUSY);
    assign w_accept   = w_isBusy & w_ownerReq & ~fifo_full & ~reset;
    assign w_lastBeat = ((r_beatCnt + c_CNT_W'(1)) == c_MAX_CNT);
    assign w_burstEnd = w_isBusy & ~reset &
                        (~w_ownerReq | (w_accept & (w_ownerLast | w_lastBeat)));

    always_comb begin
        grant = '0;
        if (w_accept) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign fifo_wen   = w_accept;
    assign fifo_wdata = w_accept ? w_ownerData : 8'h00;
    assign busy       = w_isBusy;
    assign owner      = r_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_rrPtr   <= '0;
            r_owner   <= '0;
            r_beatCnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (enable && w_found) begin
                        r_state   <= c_BUSY;
                        r_owner   <= w_pick;
                        r_beatCnt <= '0;
                    end
                end
                c_BUSY: begin
                    if (w_burstEnd) begin
                        r_state   <= c_IDLE;
                        r_rrPtr   <= w_nextPtr;
                        r_owner   <= '0;
                        r_beatCnt <= '0;
                    end else if (w_accept) begin
                        r_beatCnt <= r_beatCnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed bench with a cycle model and write-log literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   grant;
    logic              fifo_wen;
    logic [7:0]        fifo_wdata;
    logic              fifo_full = 1'b0;
    logic              busy;
    logic [1:0]        owner;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req),
        .req_data(req_data), .req_last(req_last), .grant(grant),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    bit chkOn   = 1'b0;
    int cyc     = 0;

    int wOwn[$];
    int wData[$];
    int wCyc[$];

    // Model: a burst is an owner plus a countdown of bytes still allowed
    bit mBusy = 1'b0;
    int mOwner = 0;
    int mPtr = 0;
    int mLeft = MAX_BURST;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic endBurst();
        mBusy  = 1'b0;
        mPtr   = (mOwner + 1) % NREQ;
        mOwner = 0;
    endtask

    initial begin : compare
        bit expAcc;
        int gi;
        forever begin
            @(negedge clk);
            expAcc = !reset && mBusy && req[mOwner] && !fifo_full;
            if (chkOn) begin
                chk("busy", int'(busy), int'(mBusy));
                chk("owner", int'(owner), mOwner);
                chk("grant", int'(grant), expAcc ? (1 << mOwner) : 0);
                chk("fifo_wen", int'(fifo_wen), int'(expAcc));
                chk("fifo_wdata", int'(fifo_wdata), expAcc ? int'(req_data[8*mOwner +: 8]) : 0);
                if (fifo_wen) begin
                    gi = -1;
                    for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
                    wOwn.push_back(gi);
                    wData.push_back(int'(fifo_wdata));
                    wCyc.push_back(cyc);
                end
            end
            if (reset) begin
                mBusy = 1'b0; mOwner = 0; mPtr = 0; mLeft = MAX_BURST;
            end else if (!mBusy) begin
                if (enable && req != '0) begin
                    for (int k = NREQ - 1; k >= 0; k--)
                        if (req[(mPtr + k) % NREQ]) mOwner = (mPtr + k) % NREQ;
                    mBusy = 1'b1;
                    mLeft = MAX_BURST;
                end
            end else if (!req[mOwner]) begin
                endBurst();
            end else if (expAcc) begin
                mLeft--;
                if (req_last[mOwner] || mLeft == 0) endBurst();
            end
            cyc++;
        end
    end

    task automatic doReset();
        reset = 1'b1; enable = 1'b1; req = '0; req_last = '0;
        fifo_full = 1'b0; req_data = '0;
        tick(1);
        chkOn = 1'b1;
        tick(1);
        reset = 1'b0;
        wOwn.delete(); wData.delete(); wCyc.delete();
    endtask

    initial begin
        tick(1);
        doReset();
        chk("reset_busy", int'(busy), 0);
        chk("reset_owner", int'(owner), 0);

        // Single 3-byte burst from requester 0
        req = 4'b0001; req_data = 32'h0000_0041;
        tick(1);
        chk("t1_busy_after_arb", int'(busy), 1);
        tick(2);
        req_last = 4'b0001;
        tick(1);
        req = '0; req_last = '0;
        chk("t1_busy_dropped", int'(busy), 0);
        chk("t1_nwrites", wOwn.size(), 3);
        for (int j = 0; j < wData.size(); j++) chk("t1_data", wData[j], 'h41);
        req = 4'b0011;
        tick(1);
        chk("t1_rrptr_owner", int'(owner), 1);
        req = '0;
        tick(2);

        // All requesting continuously: full-length bursts in rotation
        doReset();
        req = 4'b1111; req_data = 32'h1312_1110;
        tick(45);
        req = '0;
        chk("t2_nwrites", wOwn.size(), 40);
        for (int j = 0; j < wOwn.size(); j++) begin
            chk("t2_owner_seq", wOwn[j], (j / 8) % 4);
            chk("t2_data", wData[j], 'h10 + (j / 8) % 4);
        end
        for (int k = 1; k < 5; k++)
            if (wCyc.size() >= 8 * k + 1) chk("t2_gap", wCyc[8*k] - wCyc[8*k-1], 2);
        tick(2);

        // Owner 2 stalled by fifo_full for 5 cycles mid-burst, zero data bytes
        doReset();
        req = 4'b0100; req_data = 32'hDD00_BBAA;
        tick(4);
        fifo_full = 1'b1;
        tick(5);
        chk("t3_writes_before_release", wOwn.size(), 3);
        chk("t3_owner_held", int'(owner), 2);
        fifo_full = 1'b0;
        tick(5);
        req = '0;
        chk("t3_nwrites", wOwn.size(), 8);
        chk("t3_busy_end", int'(busy), 0);
        for (int j = 0; j < wOwn.size(); j++) begin
            chk("t3_owner", wOwn[j], 2);
            chk("t3_data", wData[j], 0);
        end
        tick(2);

        // Owner 1 withdraws after 3 bytes; next grant scans from index 2
        doReset();
        req = 4'b1010; req_data = 32'h4433_2211;
        tick(4);
        req = 4'b1000;
        tick(1);
        chk("t4_busy_end", int'(busy), 0);
        chk("t4_nwrites", wOwn.size(), 3);
        tick(1);
        chk("t4_next_owner", int'(owner), 3);
        req_last = 4'b1000;
        tick(1);
        req = '0; req_last = '0;
        chk("t4_total", wOwn.size(), 4);
        if (wOwn.size() == 4) chk("t4_last_owner", wOwn[3], 3);
        tick(2);

        // Arbitration disabled
        doReset();
        enable = 1'b0; req = 4'b0100; req_data = 32'h0077_0000;
        tick(5);
        chk("t5_busy", int'(busy), 0);
        chk("t5_nwrites", wOwn.size(), 0);
        req = '0;
        tick(1);

        // enable cleared mid-burst: burst completes, then no new grant
        doReset();
        req = 4'b0001; req_data = 32'h0000_005A;
        tick(2);
        enable = 1'b0;
        tick(1);
        req_last = 4'b0001;
        tick(1);
        req_last = '0;
        tick(4);
        chk("t6_busy", int'(busy), 0);
        chk("t6_nwrites", wOwn.size(), 3);
        req = '0; enable = 1'b1;
        tick(1);

        // Reset during a burst after 2 writes
        doReset();
        req = 4'b0010; req_data = 32'h0000_6600;
        tick(3);
        reset = 1'b1; req = 4'b0011;
        tick(1);
        chk("t7_busy", int'(busy), 0);
        chk("t7_owner", int'(owner), 0);
        chk("t7_wen", int'(fifo_wen), 0);
        chk("t7_nwrites", wOwn.size(), 2);
        reset = 1'b0;
        tick(1);
        chk("t7_restart_owner", int'(owner), 0);
        chk("t7_restart_busy", int'(busy), 1);
        req = '0;
        tick(3);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
